// File: rtl/dram_cache_pkg.sv
// Shared definitions for the DRAM cache request path: FSM states, FIFO entry
// field layout and AXI response codes used by both ends of the request FIFO.
package dram_cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_RMEM,
      S_RRESP,
      S_WDATA,
      S_WRESP
   } state_t;

   localparam int FIFO_ENTRY_WIDTH = 128;
   localparam int ID_WIDTH_DEFAULT = 16;

   // The address field starts right after the ID, so its offset moves with ID width.
   localparam int RW_BIT   = 0;
   localparam int ID_LSB   = 1;
   localparam int ADDR_LSB = ID_WIDTH_DEFAULT + 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_resp_gen.sv
// Pops one request at a time from the extractor FIFO and serves it against the
// cache data memory, returning a single-beat AXI R or B response.
module axi_resp_gen
   import dram_cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 16,
   parameter int INDEX_BIT_SIZE = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fifo_empty_i,
   output logic                        fifo_read_en_o,
   input  logic [FIFO_ENTRY_WIDTH-1:0] fifo_data_i,
   output logic [INDEX_BIT_SIZE-1:0]   mem_index_o,
   output logic                        mem_rden_o,
   output logic                        mem_wren_o,
   output logic [DATA_WIDTH-1:0]       mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]     mem_wstrb_o,
   input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
   input  logic                        mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   input  logic [DATA_WIDTH/8-1:0]     wstrb_i,
   input  logic                        wlast_i,
   input  logic                        wvalid_i,
   output logic                        wready_o,
   output logic [ID_WIDTH-1:0]         bid_o,
   output logic [1:0]                  bresp_o,
   output logic                        bvalid_o,
   input  logic                        bready_i,
   output logic [ID_WIDTH-1:0]         rid_o,
   output logic [DATA_WIDTH-1:0]       rdata_o,
   output logic [1:0]                  rresp_o,
   output logic                        rlast_o,
   output logic                        rvalid_o,
   input  logic                        rready_i
);

   localparam int ADDR_OFFSET = ID_LSB + ID_WIDTH;
   localparam int CNT_W       = $clog2(TIMEOUT_CYCLES);

   state_t                    state, state_next;
   logic [CNT_W-1:0]          cnt, cnt_next;
   logic [ID_WIDTH-1:0]       req_id, req_id_next;
   logic [ADDR_WIDTH-1:0]     req_addr;

   logic                      fifo_read_en_next;
   logic [INDEX_BIT_SIZE-1:0] mem_index_next;
   logic                      mem_rden_next;
   logic                      mem_wren_next;
   logic [DATA_WIDTH-1:0]     mem_wdata_next;
   logic [DATA_WIDTH/8-1:0]   mem_wstrb_next;
   logic                      wready_next;
   logic [ID_WIDTH-1:0]       bid_next;
   logic [1:0]                bresp_next;
   logic                      bvalid_next;
   logic [ID_WIDTH-1:0]       rid_next;
   logic [DATA_WIDTH-1:0]     rdata_next;
   logic [1:0]                rresp_next;
   logic                      rlast_next;
   logic                      rvalid_next;

   // Only the low index bits of the address and the rw/id fields matter here.
   assign req_addr = fifo_data_i[ADDR_OFFSET +: ADDR_WIDTH];

   logic unused_entry_bits;
   assign unused_entry_bits = ^{fifo_data_i, req_addr};

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         req_id         <= '0;
         fifo_read_en_o <= 1'b0;
         mem_index_o    <= '0;
         mem_rden_o     <= 1'b0;
         mem_wren_o     <= 1'b0;
         mem_wdata_o    <= '0;
         mem_wstrb_o    <= '0;
         wready_o       <= 1'b0;
         bid_o          <= '0;
         bresp_o        <= '0;
         bvalid_o       <= 1'b0;
         rid_o          <= '0;
         rdata_o        <= '0;
         rresp_o        <= '0;
         rlast_o        <= 1'b0;
         rvalid_o       <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         req_id         <= req_id_next;
         fifo_read_en_o <= fifo_read_en_next;
         mem_index_o    <= mem_index_next;
         mem_rden_o     <= mem_rden_next;
         mem_wren_o     <= mem_wren_next;
         mem_wdata_o    <= mem_wdata_next;
         mem_wstrb_o    <= mem_wstrb_next;
         wready_o       <= wready_next;
         bid_o          <= bid_next;
         bresp_o        <= bresp_next;
         bvalid_o       <= bvalid_next;
         rid_o          <= rid_next;
         rdata_o        <= rdata_next;
         rresp_o        <= rresp_next;
         rlast_o        <= rlast_next;
         rvalid_o       <= rvalid_next;
      end
   end

   // Strobes default low so they pulse for one cycle; everything else holds.
   always_comb begin
      state_next        = state;
      cnt_next          = cnt;
      req_id_next       = req_id;
      fifo_read_en_next = 1'b0;
      mem_index_next    = mem_index_o;
      mem_rden_next     = 1'b0;
      mem_wren_next     = 1'b0;
      mem_wdata_next    = mem_wdata_o;
      mem_wstrb_next    = mem_wstrb_o;
      wready_next       = wready_o;
      bid_next          = bid_o;
      bresp_next        = bresp_o;
      bvalid_next       = bvalid_o;
      rid_next          = rid_o;
      rdata_next        = rdata_o;
      rresp_next        = rresp_o;
      rlast_next        = rlast_o;
      rvalid_next       = rvalid_o;

      case (state)
         S_IDLE: begin
            if (!fifo_empty_i) begin
               fifo_read_en_next = 1'b1;
               state_next        = S_POP;
            end
         end

         S_POP: begin
            req_id_next    = fifo_data_i[ID_LSB +: ID_WIDTH];
            mem_index_next = req_addr[INDEX_BIT_SIZE-1:0];
            if (fifo_data_i[RW_BIT]) begin
               wready_next = 1'b1;
               state_next  = S_WDATA;
            end else begin
               mem_rden_next = 1'b1;
               cnt_next      = '0;
               state_next    = S_RMEM;
            end
         end

         // Valid data wins over a timeout landing on the same cycle.
         S_RMEM: begin
            if (mem_rvalid_i) begin
               rdata_next  = mem_rdata_i;
               rresp_next  = RESP_OKAY;
               rid_next    = req_id;
               rvalid_next = 1'b1;
               rlast_next  = 1'b1;
               state_next  = S_RRESP;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_next  = '0;
               rresp_next  = RESP_SLVERR;
               rid_next    = req_id;
               rvalid_next = 1'b1;
               rlast_next  = 1'b1;
               state_next  = S_RRESP;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         S_RRESP: begin
            if (rready_i) begin
               rvalid_next = 1'b0;
               rlast_next  = 1'b0;
               state_next  = S_IDLE;
            end
         end

         // Multi-beat bursts are not supported: a non-last beat is consumed
         // without touching memory and answered with SLVERR.
         S_WDATA: begin
            if (wvalid_i && wready_o) begin
               wready_next = 1'b0;
               bid_next    = req_id;
               bvalid_next = 1'b1;
               state_next  = S_WRESP;
               if (wlast_i) begin
                  mem_wren_next  = 1'b1;
                  mem_wdata_next = wdata_i;
                  mem_wstrb_next = wstrb_i;
                  bresp_next     = RESP_OKAY;
               end else begin
                  bresp_next = RESP_SLVERR;
               end
            end
         end

         S_WRESP: begin
            if (bready_i) begin
               bvalid_next = 1'b0;
               state_next  = S_IDLE;
            end
         end

         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_resp_gen.sv
// Self-checking bench for axi_resp_gen: directed scenarios followed by random
// traffic, scored against an in-order transaction model with its own memory image.
module tb_axi_resp_gen;
   import dram_cache_pkg::*;

   localparam int TO     = 16;
   localparam int BUDGET = 60;

   logic          clk;
   logic          rst;
   logic          fifo_empty_i;
   logic          fifo_read_en_o;
   logic [127:0]  fifo_data_i;
   logic [3:0]    mem_index_o;
   logic          mem_rden_o;
   logic          mem_wren_o;
   logic [31:0]   mem_wdata_o;
   logic [3:0]    mem_wstrb_o;
   logic [31:0]   mem_rdata_i;
   logic          mem_rvalid_i;
   logic [31:0]   wdata_i;
   logic [3:0]    wstrb_i;
   logic          wlast_i;
   logic          wvalid_i;
   logic          wready_o;
   logic [15:0]   bid_o;
   logic [1:0]    bresp_o;
   logic          bvalid_o;
   logic          bready_i;
   logic [15:0]   rid_o;
   logic [31:0]   rdata_o;
   logic [1:0]    rresp_o;
   logic          rlast_o;
   logic          rvalid_o;
   logic          rready_i;

   axi_resp_gen #(
      .ADDR_WIDTH    (64),
      .DATA_WIDTH    (32),
      .ID_WIDTH      (16),
      .INDEX_BIT_SIZE(4),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_read_en_o(fifo_read_en_o),
      .fifo_data_i   (fifo_data_i),
      .mem_index_o   (mem_index_o),
      .mem_rden_o    (mem_rden_o),
      .mem_wren_o    (mem_wren_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_wstrb_o   (mem_wstrb_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .wdata_i       (wdata_i),
      .wstrb_i       (wstrb_i),
      .wlast_i       (wlast_i),
      .wvalid_i      (wvalid_i),
      .wready_o      (wready_o),
      .bid_o         (bid_o),
      .bresp_o       (bresp_o),
      .bvalid_o      (bvalid_o),
      .bready_i      (bready_i),
      .rid_o         (rid_o),
      .rdata_o       (rdata_o),
      .rresp_o       (rresp_o),
      .rlast_o       (rlast_o),
      .rvalid_o      (rvalid_o),
      .rready_i      (rready_i)
   );

   typedef struct {
      logic        isWrite;
      logic [15:0] id;
      logic [3:0]  idx;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
   } ExpRec;

   ExpRec        expQ[$];
   logic [127:0] fifoQ[$];
   logic [31:0]  refMem[16];
   logic [31:0]  memArray[16];

   int compared = 0;
   int failed   = 0;
   int cycle    = 0;

   bit memMute    = 1'b0;
   int memLatency = 1;

   int          popCount   = 0;
   int          readEnRise = 0;
   int          rdenCount  = 0;
   int          rdenCycle  = 0;
   logic [3:0]  rdenIdx    = '0;
   int          rvalidRise = 0;
   int          wrenCount  = 0;
   logic [3:0]  lastWIdx   = '0;
   logic [31:0] lastWData  = '0;
   logic [3:0]  lastWStrb  = '0;
   bit          prevRe     = 1'b0;
   bit          prevRv     = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         failed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Queue one FIFO entry and record the response the transaction must produce.
   task automatic applyStimulus(input logic rw, input logic [15:0] id, input logic [63:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb, input logic wlast);
      ExpRec       e;
      logic [46:0] pad;
      pad = 47'({$urandom(), $urandom()});
      fifoQ.push_back({pad, addr, id, rw});
      e.isWrite = rw;
      e.id      = id;
      e.idx     = addr[3:0];
      e.wdata   = wdata;
      e.wstrb   = wstrb;
      e.wlast   = wlast;
      e.data    = '0;
      if (!rw) begin
         e.resp = memMute ? 2'b10 : 2'b00;
         e.data = memMute ? 32'h0 : refMem[addr[3:0]];
      end else begin
         e.resp = wlast ? 2'b00 : 2'b10;
         if (wlast) begin
            for (int b = 0; b < 4; b++) begin
               if (wstrb[b]) refMem[addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
      expQ.push_back(e);
   endtask

   // Drive the oldest outstanding transaction to completion and score it.
   task automatic serviceOne(input int holdCycles);
      ExpRec e;
      bit    hs;
      int    wrenBefore;
      int    popBefore;
      checkOutput("exp_queue_nonempty", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      if (e.isWrite) begin
         wrenBefore = wrenCount;
         wvalid_i = 1'b1;
         wdata_i  = e.wdata;
         wstrb_i  = e.wstrb;
         wlast_i  = e.wlast;
         hs = 1'b0;
         for (int n = 0; n < BUDGET && !hs; n++) begin
            hs = wready_o;
            tick();
         end
         wvalid_i = 1'b0;
         wdata_i  = $urandom();
         wlast_i  = 1'b0;
         checkOutput("w_handshake", 64'(hs), 64'd1);
         checkOutput("wready_drop", 64'(wready_o), 64'd0);
         for (int n = 0; n < BUDGET && !bvalid_o; n++) tick();
         checkOutput("bvalid_seen", 64'(bvalid_o), 64'd1);
         for (int h = 0; h < holdCycles; h++) begin
            checkOutput("bid_hold", 64'(bid_o), 64'(e.id));
            checkOutput("bresp_hold", 64'(bresp_o), 64'(e.resp));
            tick();
         end
         checkOutput("bid", 64'(bid_o), 64'(e.id));
         checkOutput("bresp", 64'(bresp_o), 64'(e.resp));
         bready_i = 1'b1;
         tick();
         bready_i = 1'b0;
         checkOutput("bvalid_drop", 64'(bvalid_o), 64'd0);
         checkOutput("wren_count", 64'(wrenCount - wrenBefore), e.wlast ? 64'd1 : 64'd0);
         if (e.wlast) begin
            checkOutput("wr_index", 64'(lastWIdx), 64'(e.idx));
            checkOutput("wr_data", 64'(lastWData), 64'(e.wdata));
            checkOutput("wr_strb", 64'(lastWStrb), 64'(e.wstrb));
         end
      end else begin
         for (int n = 0; n < BUDGET && !rvalid_o; n++) tick();
         checkOutput("rvalid_seen", 64'(rvalid_o), 64'd1);
         popBefore = popCount;
         for (int h = 0; h < holdCycles; h++) begin
            checkOutput("rid_hold", 64'(rid_o), 64'(e.id));
            checkOutput("rdata_hold", 64'(rdata_o), 64'(e.data));
            checkOutput("rresp_hold", 64'(rresp_o), 64'(e.resp));
            checkOutput("no_pop_while_busy", 64'(popCount), 64'(popBefore));
            tick();
         end
         checkOutput("rid", 64'(rid_o), 64'(e.id));
         checkOutput("rdata", 64'(rdata_o), 64'(e.data));
         checkOutput("rresp", 64'(rresp_o), 64'(e.resp));
         checkOutput("rlast", 64'(rlast_o), 64'd1);
         rready_i = 1'b1;
         tick();
         rready_i = 1'b0;
         checkOutput("rvalid_drop", 64'(rvalid_o), 64'd0);
         checkOutput("rlast_drop", 64'(rlast_o), 64'd0);
         checkOutput("rd_index", 64'(rdenIdx), 64'(e.idx));
      end
   endtask

   // Show-ahead FIFO: the head entry is always presented and leaves on a sampled pop.
   initial begin
      bit popPending;
      popPending   = 1'b0;
      fifo_empty_i = 1'b1;
      fifo_data_i  = '0;
      forever begin
         tick();
         if (popPending && fifoQ.size() > 0) void'(fifoQ.pop_front());
         popPending = fifo_read_en_o;
         if (fifoQ.size() > 0) fifo_data_i = fifoQ[0];
         fifo_empty_i = (fifoQ.size() == 0);
      end
   end

   // Cache data memory: answers a read strobe after memLatency cycles unless muted.
   initial begin
      logic [3:0] idx;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         tick();
         if (mem_rden_o && !memMute) begin
            idx = mem_index_o;
            repeat (memLatency) tick();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memArray[idx];
            tick();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom();
         end
      end
   end

   // Passive observer sampling on the falling edge, clear of register updates.
   initial begin
      forever begin
         @(negedge clk);
         if (fifo_read_en_o) begin
            popCount++;
            if (!prevRe) readEnRise = cycle;
         end
         prevRe = fifo_read_en_o;
         if (mem_rden_o) begin
            rdenCount++;
            rdenCycle = cycle;
            rdenIdx   = mem_index_o;
         end
         if (rvalid_o && !prevRv) rvalidRise = cycle;
         prevRv = rvalid_o;
         if (mem_wren_o) begin
            wrenCount++;
            lastWIdx  = mem_index_o;
            lastWData = mem_wdata_o;
            lastWStrb = mem_wstrb_o;
            for (int b = 0; b < 4; b++) begin
               if (mem_wstrb_o[b]) memArray[mem_index_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int popStart;
      int wrenStart;
      logic        rw;
      logic        wl;
      logic [15:0] id;
      logic [63:0] addr;

      for (int i = 0; i < 16; i++) begin
         memArray[i] = $urandom();
         refMem[i]   = memArray[i];
      end
      memArray[3] = 32'hDEADBEEF;
      refMem[3]   = 32'hDEADBEEF;

      rst      = 1'b1;
      wdata_i  = '0;
      wstrb_i  = '0;
      wlast_i  = 1'b0;
      wvalid_i = 1'b0;
      bready_i = 1'b0;
      rready_i = 1'b0;
      repeat (3) tick();

      $display("[TB] reset state");
      checkOutput("rst_rvalid", 64'(rvalid_o), 64'd0);
      checkOutput("rst_bvalid", 64'(bvalid_o), 64'd0);
      checkOutput("rst_wready", 64'(wready_o), 64'd0);
      checkOutput("rst_read_en", 64'(fifo_read_en_o), 64'd0);
      checkOutput("rst_rden", 64'(mem_rden_o), 64'd0);
      checkOutput("rst_wren", 64'(mem_wren_o), 64'd0);
      rst = 1'b0;
      repeat (4) tick();
      checkOutput("no_pop_when_empty", 64'(popCount), 64'd0);

      $display("[TB] read hit");
      applyStimulus(1'b0, 16'h00A5, 64'h13, '0, '0, 1'b0);
      serviceOne(0);
      checkOutput("read_latency", 64'(rvalidRise - readEnRise), 64'd3);

      $display("[TB] early W beat then write");
      wrenStart = wrenCount;
      wvalid_i  = 1'b1;
      wdata_i   = 32'hCAFEF00D;
      wstrb_i   = 4'hF;
      wlast_i   = 1'b1;
      repeat (2) tick();
      checkOutput("early_wready", 64'(wready_o), 64'd0);
      wvalid_i = 1'b0;
      checkOutput("early_no_wren", 64'(wrenCount - wrenStart), 64'd0);
      applyStimulus(1'b1, 16'h0007, 64'h2F, 32'h12345678, 4'hF, 1'b1);
      serviceOne(0);

      $display("[TB] read timeout");
      memMute = 1'b1;
      applyStimulus(1'b0, 16'h0101, 64'h5, '0, '0, 1'b0);
      serviceOne(0);
      checkOutput("timeout_latency", 64'(rvalidRise - rdenCycle), 64'(TO));
      memMute = 1'b0;

      $display("[TB] read backpressure");
      applyStimulus(1'b0, 16'h0BB0, 64'h9, '0, '0, 1'b0);
      applyStimulus(1'b0, 16'h0BB1, 64'hA, '0, '0, 1'b0);
      serviceOne(5);
      checkOutput("no_pop_at_handshake", 64'(fifo_read_en_o), 64'd0);
      tick();
      checkOutput("pop_after_handshake", 64'(fifo_read_en_o), 64'd1);
      serviceOne(0);

      $display("[TB] burst reject");
      applyStimulus(1'b1, 16'h0033, 64'h4, 32'hA5A5A5A5, 4'hF, 1'b0);
      serviceOne(2);

      $display("[TB] ordering R W R");
      popStart = popCount;
      applyStimulus(1'b0, 16'h0201, 64'h2F, '0, '0, 1'b0);
      applyStimulus(1'b1, 16'h0202, 64'h11, 32'h55AA33CC, 4'b0101, 1'b1);
      applyStimulus(1'b0, 16'h0203, 64'h1, '0, '0, 1'b0);
      serviceOne(0);
      serviceOne(1);
      serviceOne(0);
      tick();
      checkOutput("order_pops", 64'(popCount - popStart), 64'd3);

      $display("[TB] reset mid-read");
      memMute = 1'b1;
      applyStimulus(1'b0, 16'h0777, 64'h6, '0, '0, 1'b0);
      for (int n = 0; n < BUDGET && !mem_rden_o; n++) tick();
      checkOutput("midrst_rden_seen", 64'(mem_rden_o), 64'd1);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checkOutput("midrst_rvalid", 64'(rvalid_o), 64'd0);
      checkOutput("midrst_index", 64'(mem_index_o), 64'd0);
      checkOutput("midrst_rid", 64'(rid_o), 64'd0);
      checkOutput("midrst_rdata", 64'(rdata_o), 64'd0);
      checkOutput("midrst_bid", 64'(bid_o), 64'd0);
      checkOutput("midrst_wdata", 64'(mem_wdata_o), 64'd0);
      rst = 1'b0;
      void'(expQ.pop_back());
      repeat (TO + 4) tick();
      checkOutput("midrst_no_response", 64'(rvalid_o), 64'd0);
      memMute = 1'b0;
      applyStimulus(1'b0, 16'h0888, 64'h3, '0, '0, 1'b0);
      serviceOne(1);

      $display("[TB] random traffic");
      for (int t = 0; t < 24; t++) begin
         rw         = 1'($urandom_range(0, 1));
         id         = 16'($urandom());
         addr       = {$urandom(), $urandom()};
         wl         = ($urandom_range(0, 7) != 0);
         memMute    = (!rw && ($urandom_range(0, 5) == 0));
         memLatency = $urandom_range(1, 4);
         applyStimulus(rw, id, addr, $urandom(), 4'($urandom()), wl);
         serviceOne($urandom_range(0, 3));
         memMute = 1'b0;
      end
      memLatency = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
